// File: rtl/fpu_op_responder.sv
// Request/response wrapper around a double-precision FPU core: launches one op per handshake,
// waits for completion or timeout, then holds the result until the consumer takes it.
module fpu_op_responder #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] QNAN        = 64'h7FF8_0000_0000_0000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [1:0]        req_rmode,
    input  logic [DATA_W-1:0] req_opa,
    input  logic [DATA_W-1:0] req_opb,

    output logic              core_enable,
    output logic [2:0]        core_op,
    output logic [1:0]        core_rmode,
    output logic [DATA_W-1:0] core_opa,
    output logic [DATA_W-1:0] core_opb,
    input  logic              core_ready,
    input  logic [DATA_W-1:0] core_out,
    input  logic [4:0]        core_flags,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [4:0]        rsp_flags,
    output logic              rsp_timeout
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);
    localparam logic [2:0] MaxLegalOp = 3'd4;
    localparam logic [4:0] FlagInvalid = 5'b10000;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        rmode_q, rmode_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [4:0]        flags_q, flags_d;
    logic              timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rmode_d   = rmode_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        flags_d   = flags_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_op <= MaxLegalOp) begin
                        op_d    = req_op;
                        rmode_d = req_rmode;
                        opa_d   = req_opa;
                        opb_d   = req_opb;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        // Illegal op answers directly without touching the core.
                        result_d  = QNAN;
                        flags_d   = FlagInvalid;
                        timeout_d = 1'b0;
                        state_d   = StResp;
                    end
                end
            end
            StBusy: begin
                // Completion takes priority over a timeout on the same edge.
                if (core_ready) begin
                    result_d  = core_out;
                    flags_d   = core_flags;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == CntMax) begin
                    result_d  = QNAN;
                    flags_d   = FlagInvalid;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            rmode_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rmode_q   <= rmode_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign core_enable = (state_q == StBusy);
    assign rsp_valid   = (state_q == StResp);
    assign core_op     = op_q;
    assign core_rmode  = rmode_q;
    assign core_opa    = opa_q;
    assign core_opb    = opb_q;
    assign rsp_result  = result_q;
    assign rsp_flags   = flags_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fpu_op_responder.sv
// Directed and random transactions against fpu_op_responder with a behavioural response model.
module tb_fpu_op_responder;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned TO     = 64;
    localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [2:0]        req_op;
    logic [1:0]        req_rmode;
    logic [DATA_W-1:0] req_opa, req_opb;
    logic              core_enable;
    logic [2:0]        core_op;
    logic [1:0]        core_rmode;
    logic [DATA_W-1:0] core_opa, core_opb;
    logic              core_ready;
    logic [DATA_W-1:0] core_out;
    logic [4:0]        core_flags;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [4:0]        rsp_flags;
    logic              rsp_timeout;

    fpu_op_responder #(
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TO),
        .QNAN       (QNAN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rmode  (req_rmode),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .core_enable(core_enable),
        .core_op    (core_op),
        .core_rmode (core_rmode),
        .core_opa   (core_opa),
        .core_opb   (core_opb),
        .core_ready (core_ready),
        .core_out   (core_out),
        .core_flags (core_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        timeout;
    } rsp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    rsp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Legal ops finish normally iff the core answers within TO cycles of enable.
    function automatic rsp_t model(input logic [2:0] op, input int j, input logic [63:0] out,
                                   input logic [4:0] fl);
        rsp_t r;
        if (op > 3'd4) begin
            r.result = QNAN; r.flags = 5'b10000; r.timeout = 1'b0;
        end else if (j >= 1 && j <= int'(TO)) begin
            r.result = out; r.flags = fl; r.timeout = 1'b0;
        end else begin
            r.result = QNAN; r.flags = 5'b10000; r.timeout = 1'b1;
        end
        return r;
    endfunction

    // j: core_ready sampled on the j-th edge after launch (0 = never). Called at a negedge.
    task automatic run_txn(input string tag, input logic [2:0] op, input logic [1:0] rm,
                           input logic [63:0] a, input logic [63:0] b, input int j,
                           input logic [63:0] out, input logic [4:0] fl, input int stall);
        rsp_t e;
        int   cyc;
        bit   bad;
        check({tag, "/req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_rmode = rm; req_opa = a; req_opb = b;
        exp_q.push_back(model(op, j, out, fl));
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'($urandom); req_opa = {$urandom, $urandom};
        if (op <= 3'd4) begin
            check({tag, "/core_enable"}, 64'(core_enable), 64'd1);
            check({tag, "/core_op"}, 64'(core_op), 64'(op));
            check({tag, "/core_rmode"}, 64'(core_rmode), 64'(rm));
            check({tag, "/core_opa"}, core_opa, a);
            check({tag, "/core_opb"}, core_opb, b);
            cyc = 0; bad = 0;
            while (core_enable && cyc < int'(TO) + 8) begin
                if (req_ready || rsp_valid) bad = 1;
                cyc++;
                core_ready = (cyc == j);
                core_out   = (cyc == j) ? out : {$urandom, $urandom};
                core_flags = (cyc == j) ? fl : 5'($urandom);
                @(negedge clk);
            end
            core_ready = 1'b0;
            check({tag, "/busy_cycles"}, 64'(cyc), 64'((j >= 1 && j <= int'(TO)) ? j : int'(TO)));
            check({tag, "/busy_handshake"}, 64'(bad), 64'd0);
        end else begin
            check({tag, "/no_launch"}, 64'(core_enable), 64'd0);
        end
        check({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "/req_ready_low"}, 64'(req_ready), 64'd0);
        if (exp_q.size() == 0) begin
            check({tag, "/scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            n_rsp++;
            check({tag, "/result"}, rsp_result, e.result);
            check({tag, "/flags"}, 64'(rsp_flags), 64'(e.flags));
            check({tag, "/timeout"}, 64'(rsp_timeout), 64'(e.timeout));
            bad = 0;
            repeat (stall) begin
                req_valid  = 1'b1; req_op = 3'($urandom);
                core_ready = 1'($urandom_range(0, 1)); core_out = {$urandom, $urandom};
                @(negedge clk);
                if (!rsp_valid || rsp_result !== e.result || rsp_flags !== e.flags ||
                    rsp_timeout !== e.timeout || req_ready || core_enable) bad = 1;
            end
            req_valid = 1'b0; core_ready = 1'b0;
            check({tag, "/hold"}, 64'(bad), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "/rsp_done"}, 64'(rsp_valid), 64'd0);
        check({tag, "/back_idle"}, 64'(req_ready), 64'd1);
        check({tag, "/idle_no_core"}, 64'(core_enable), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rmode = '0; req_opa = '0; req_opb = '0;
        core_ready = 1'b0; core_out = '0; core_flags = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset/req_ready", 64'(req_ready), 64'd1);
        check("reset/core_enable", 64'(core_enable), 64'd0);
        check("reset/rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset/rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("reset/rsp_result", rsp_result, 64'd0);
        check("reset/core_opa", core_opa, 64'd0);

        run_txn("add", 3'd0, 2'd0, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 5,
                64'h4008_0000_0000_0000, 5'b00000, 0);
        run_txn("div0", 3'd3, 2'd1, 64'h3FF0_0000_0000_0000, 64'h0, 3,
                64'h7FF0_0000_0000_0000, 5'b01000, 4);
        run_txn("illegal", 3'd6, 2'd2, 64'h1234, 64'h5678, 0, 64'h0, 5'b0, 1);
        run_txn("mul_to", 3'd2, 2'd3, 64'h4010_0000_0000_0000, 64'h4014_0000_0000_0000, 0,
                64'h0, 5'b0, 3);

        // Stray completion pulse in IDLE must not produce anything.
        core_ready = 1'b1; core_out = 64'hDEAD_BEEF;
        @(negedge clk);
        core_ready = 1'b0;
        @(negedge clk);
        check("stray_idle/rsp_valid", 64'(rsp_valid), 64'd0);
        check("stray_idle/core_enable", 64'(core_enable), 64'd0);
        check("stray_idle/result_kept", rsp_result, QNAN);

        run_txn("edge_ready", 3'd1, 2'd0, 64'h1, 64'h2, int'(TO),
                64'h4000_0000_0000_0001, 5'b00001, 0);
        run_txn("edge_late", 3'd4, 2'd0, 64'h4010_0000_0000_0000, 64'h0, int'(TO) + 1,
                64'h4000_0000_0000_0000, 5'b0, 0);

        // Reset in the middle of an operation.
        req_valid = 1'b1; req_op = 3'd2; req_rmode = 2'd1;
        req_opa = 64'hAAAA_5555_AAAA_5555; req_opb = 64'h1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid/busy", 64'(core_enable), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid/req_ready", 64'(req_ready), 64'd1);
        check("rst_mid/core_enable", 64'(core_enable), 64'd0);
        check("rst_mid/rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid/rsp_result", rsp_result, 64'd0);
        check("rst_mid/rsp_flags", 64'(rsp_flags), 64'd0);
        check("rst_mid/core_op", 64'(core_op), 64'd0);
        check("rst_mid/core_opa", core_opa, 64'd0);
        core_ready = 1'b1; core_out = 64'h4008_0000_0000_0000;
        @(negedge clk);
        core_ready = 1'b0;
        @(negedge clk);
        check("rst_mid/late_ready", 64'(rsp_valid), 64'd0);
        check("rst_mid/late_enable", 64'(core_enable), 64'd0);

        base = n_rsp;
        for (int i = 0; i < 10; i++) begin
            logic [2:0] op;
            int j;
            op = 3'($urandom_range(0, 7));
            j  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            run_txn($sformatf("rand%0d", i), op, 2'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom}, j, {$urandom, $urandom}, 5'($urandom),
                    int'($urandom_range(0, 3)));
        end
        check("rand/response_count", 64'(n_rsp - base), 64'd10);
        check("rand/scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_op_responder.md
Name: fpu_op_responder

Overview:
- DUT-side responder for the FPU request/response transaction interface driven by the FPU agent.
- Accepts one operation per handshake and launches it on the double-precision FPU core.
- Waits for core completion or a timeout, then holds the result and exception flags until the consumer acknowledges.
- Sits between the bench/system request channel and the FPU core; the monitor and scoreboard observe its req/rsp channels.

Parameters:
- DATA_W, 64, operand/result width (IEEE-754 double)
- TIMEOUT_CYC, 64, max cycles waiting for core_ready before forcing a timeout response (must be ≥ 2)
- QNAN, 64'h7FF8_0000_0000_0000, canonical result for illegal-op and timeout responses

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_op  in  3  0=add 1=sub 2=mul 3=div 4=sqrt; 5..7 illegal
- req_rmode  in  2  0=nearest 1=zero 2=+inf 3=-inf
- req_opa  in  DATA_W  operand A
- req_opb  in  DATA_W  operand B (ignored for sqrt)
- core_enable  out  1  held high while the core operation is in flight
- core_op  out  3  latched op to core
- core_rmode  out  2  latched rounding mode
- core_opa  out  DATA_W  latched operand A
- core_opb  out  DATA_W  latched operand B
- core_ready  in  1  core completion pulse; sampled only while core_enable=1
- core_out  in  DATA_W  core result, valid when core_ready=1
- core_flags  in  5  {invalid, div_zero, overflow, underflow, inexact}, valid with core_ready
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  result
- rsp_flags  out  5  exception flags, same bit order as core_flags
- rsp_timeout  out  1  response produced by timeout

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - req_ready=1, core_enable=0, rsp_valid=0, rsp_timeout=0.
  - rsp_result=0, rsp_flags=0, core_op/rmode/opa/opb=0, wait counter=0.
  - Reset overrides any in-flight operation; a core_ready arriving after reset is ignored.
- IDLE:
  - req_ready=1. A request is accepted when req_valid=1 at the edge.
  - Legal op (0..4): latch the core_* fields, core_enable=1 next cycle, counter=0, go to BUSY.
  - Illegal op (5..7): no core launch. Next cycle rsp_valid=1, rsp_result=QNAN, rsp_flags=5'b10000, rsp_timeout=0; go to RESP.
- BUSY:
  - req_ready=0, core_enable=1, counter increments each cycle.
  - core_ready=1: capture core_out and core_flags into rsp_*, core_enable=0, rsp_valid=1 next cycle, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 with core_ready=0: core_enable=0, rsp_result=QNAN, rsp_flags=5'b10000, rsp_timeout=1, go to RESP.
  - core_ready on the same edge as the timeout threshold: core_ready wins and rsp_timeout=0.
- RESP:
  - rsp_valid=1 with rsp_* held stable, req_ready=0.
  - When rsp_ready=1: rsp_valid=0 next cycle, go to IDLE, req_ready=1 next cycle.
  - No same-cycle re-accept; minimum issue interval is 3 cycles.
- core_ready outside BUSY is ignored.
- core_* operand registers hold their last value after completion.
- Latency: request accepted at edge T → core_enable high from T+1. core_ready at edge N → rsp_valid at N+1.
- Req-channel inputs are ignored while req_ready=0; an upstream holding req_valid is not consumed.

Test Plan:
- Reset, then add opa=0x3FF0000000000000 (1.0), opb=0x4000000000000000 (2.0), rmode=0. Model core_ready 5 cycles after launch with core_out=0x4008000000000000, flags=0 → rsp_valid 1 cycle after core_ready, rsp_result=0x4008000000000000, flags=0, timeout=0, req_ready=0 throughout.
- Div opa=1.0, opb=0. Core returns 0x7FF0000000000000 with flags=5'b01000 → response carries the same; hold rsp_ready=0 for 4 cycles → rsp_* stable, req_valid ignored.
- req_op=6 → no core_enable pulse; rsp_valid next cycle, result=0x7FF8000000000000, flags=5'b10000, timeout=0.
- Mul with core never asserting core_ready → core_enable drops and rsp_valid=1 after TIMEOUT_CYC cycles, rsp_timeout=1, result=QNAN. A later stray core_ready in RESP/IDLE has no effect.
- core_ready exactly on the timeout-threshold cycle → normal response, rsp_timeout=0.
- rst asserted mid-BUSY → all outputs at reset values next cycle; core_ready one cycle later ignored. Back-to-back 10 random ops with random rsp_ready stalls → exactly 10 responses, in order.
